regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the 5-stage ARM pipeline; successor to the 2R/1W regfile.
//  Adds NRD read ports and NWR write ports, a hardwired zero register (XZR), and per-register
//  busy scoreboard bits with issue-time reservation.
//  Sits between ID (reads, reservations) and WB (writes); busy outputs feed the hazard unit.
// PARAMETERS
//  WIDTH    64  data width in bits
//  DEPTH    32  number of architectural registers
//  NRD      2   number of read ports
//  NWR      2   number of write ports
//  ZERO_REG 31  index that always reads 0 and ignores writes; ZERO_REG>=DEPTH disables the zero register
//  (local) AW = $clog2(DEPTH)
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high
//  rd_addr      in   NRD*AW     read addresses; port i = bits [i*AW +: AW]
//  rd_data      out  NRD*WIDTH  read data; combinational
//  rd_busy      out  NRD        busy bit of each rd_addr; combinational
//  wr_en        in   NWR        per-port write enable
//  wr_addr      in   NWR*AW     write addresses
//  wr_data      in   NWR*WIDTH  write data
//  rsv_en       in   1          reserve a destination register (instruction issued)
//  rsv_addr     in   AW         register to mark busy
//  busy         out  DEPTH      scoreboard vector; registered
//  wr_conflict  out  1          registered one-cycle pulse: >=2 enabled write ports hit the same address
// BEHAVIOUR
//  - Reset (posedge clk with reset=1): all registers 0, busy=0, wr_conflict=0. Reset overrides any
//    write or reservation in the same cycle. Reset mid-operation discards all pending state.
//  - Write: at posedge, for each enabled port, reg[wr_addr] <= wr_data.
//  - Same-address writes: the highest port index wins; wr_conflict=1 in the next cycle only.
//  - Zero register: ZERO_REG reads 0. Writes and reservations to it are dropped; it is never busy.
//  - Out-of-range address (addr>=DEPTH): reads return 0 and rd_busy=0; writes and reservations are dropped.
//  - Scoreboard:
//      busy[a] set at posedge when rsv_en && rsv_addr==a.
//      busy[a] cleared at posedge when any enabled write port has wr_addr==a.
//      Reservation and write to the same a in one cycle: set wins (a new producer is issued).
//      rsv_en on an already-busy register keeps it busy (no count; single outstanding producer).
//  - Reads: rd_data[i] = reg[rd_addr[i]], with no added latency. Any number of ports may read the
//    same address.
//  - rd_busy[i] = busy[rd_addr[i]], subject to the bypass rule below.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    A read whose address matches an enabled write this cycle returns that wr_data (highest
//    matching port) and rd_busy[i]=0. Gives write-to-read forwarding in the same cycle.
//  Not defined:
//    Reads return the pre-edge register value. rd_busy reflects the registered busy bit only.
//    The hazard unit stalls one extra cycle.
// STRUCTURE
//  - Package regfile_pkg holds:
//      typedef logic [4:0] reg_addr_t
//      typedef logic [63:0] reg_data_t
//      localparam XZR = 31
//      localparam NUM_ARCH_REGS = 32
//  - Sub-module regfile_scoreboard (DEPTH, NWR, ZERO_REG) holds the busy vector:
//      set/clear priority logic and the wr_conflict detector.
//  - Storage array and read muxes are written as behavioural generate loops in regfile_mp.
// TESTING
//  1. Reset: write 0xDEAD to r3, assert reset, read r3 -> 0; busy=0; wr_conflict=0.
//  2. Dual write: port0 r5=0x11 and port1 r6=0x22 in one cycle -> next cycle r5=0x11, r6=0x22,
//     wr_conflict=0.
//  3. Conflict: port0 r7=0xAA and port1 r7=0xBB in one cycle -> r7=0xBB; wr_conflict=1 for exactly one cycle.
//  4. XZR: write r31=0xFFFF and rsv_en r31 -> r31 reads 0; busy[31]=0.
//  5. Scoreboard: rsv r9 -> busy[9]=1 and rd_busy=1 when reading r9. Write r9=0x5 -> busy[9]=0.
//     Rsv r9 and write r9 in the same cycle -> busy[9] stays 1.
//  6. Bypass: read r4 while writing r4=0x77.
//       With REGFILE_BYPASS_EN: rd_data=0x77 and rd_busy=0 in the same cycle.
//       Without: old value; 0x77 appears the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and architectural constants for the multi-port register file.
package regfile_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

  localparam int XZR           = 31;
  localparam int NUM_ARCH_REGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with issue-time reservation, plus the
// same-cycle write-port collision detector that drives wr_conflict.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = NUM_ARCH_REGS,
  parameter int NWR      = 2,
  parameter int ZERO_REG = XZR,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [DEPTH-1:0]  busy,
  output logic              wr_conflict
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             conflict_d;
  logic             conflict_q;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
  endfunction

  // Collisions count even for dropped targets: two ports still fought over one address.
  always_comb begin
    set_vec    = '0;
    clr_vec    = '0;
    conflict_d = 1'b0;
    if (rsv_en && addr_ok(rsv_addr))
      set_vec[rsv_addr] = 1'b1;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && addr_ok(wr_addr[p*AW +: AW]))
        clr_vec[wr_addr[p*AW +: AW]] = 1'b1;
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_addr[p*AW +: AW] == wr_addr[q*AW +: AW]))
          conflict_d = 1'b1;
      end
    end
  end

  // A fresh reservation beats a retiring write to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= (busy_q & ~clr_vec) | set_vec;
      conflict_q <= conflict_d;
    end
  end

  assign busy        = busy_q;
  assign wr_conflict = conflict_q;

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / NWR-write register file with zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = $bits(reg_data_t),
  parameter int DEPTH    = NUM_ARCH_REGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = XZR,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [DEPTH-1:0]     busy,
  output logic                 wr_conflict
);

  logic [WIDTH-1:0] regs [DEPTH];

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
  endfunction

  // Ports are applied in ascending order so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++)
        regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && addr_ok(wr_addr[p*AW +: AW]))
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy        (busy),
    .wr_conflict (wr_conflict)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             bsy;

    assign addr = rd_addr[i*AW +: AW];

    // Zero register and out-of-range reads fall through to 0 / not busy.
    always_comb begin
      data = '0;
      bsy  = 1'b0;
      if (addr_ok(addr)) begin
        data = regs[addr];
        bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
            data = wr_data[p*WIDTH +: WIDTH];
            bsy  = 1'b0;
          end
        end
`endif
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = data;
    assign rd_busy[i]                = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected observations,
// a negedge monitor pops and compares them. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int W  = 64;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*AW-1:0] rd_addr;
  logic [2*W-1:0]  rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*W-1:0]  wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [31:0]     busy;
  logic            wr_conflict;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  int        q_cyc  [$];
  int        q_kind [$];
  reg_data_t q_exp  [$];
  string     q_name [$];

  localparam int K_RD0 = 0, K_RD1 = 1, K_RB0 = 2, K_RB1 = 3, K_BUSY = 4, K_CONF = 5;

  regfile_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy        (busy),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic rst,
                               input logic we0, input int wa0, input reg_data_t wd0,
                               input logic we1, input int wa1, input reg_data_t wd1,
                               input logic rsv, input int ra,
                               input int r0, input int r1);
    @(posedge clk);
    #1;
    reset    = rst;
    wr_en    = {we1, we0};
    wr_addr  = {wa1[AW-1:0], wa0[AW-1:0]};
    wr_data  = {wd1, wd0};
    rsv_en   = rsv;
    rsv_addr = ra[AW-1:0];
    rd_addr  = {r1[AW-1:0], r0[AW-1:0]};
  endtask

  task automatic idle(input int r0, input int r1);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, r0, r1);
  endtask

  task automatic pushExpect(input int kind, input reg_data_t exp, input string name);
    q_cyc.push_back(cyc);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  task automatic checkOutput(input int kind, input reg_data_t exp, input string name);
    reg_data_t act;
    case (kind)
      K_RD0:   act = rd_data[W-1:0];
      K_RD1:   act = rd_data[2*W-1:W];
      K_RB0:   act = {63'd0, rd_busy[0]};
      K_RB1:   act = {63'd0, rd_busy[1]};
      K_BUSY:  act = {32'd0, busy};
      default: act = {63'd0, wr_conflict};
    endcase
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes every observation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      if (q_cyc[0] < cyc) begin
        tests++;
        failed++;
        $display("[TB] FAIL %s: stale observation for cycle %0d at cycle %0d", q_name[0], q_cyc[0], cyc);
      end else begin
        checkOutput(q_kind[0], q_exp[0], q_name[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_kind.pop_front());
      void'(q_exp.pop_front());
      void'(q_name.pop_front());
    end
  end

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    // Reset overrides a same-cycle write and reservation
    applyStimulus(1'b0, 1'b1, 3, 64'hDEAD, 1'b0, 0, '0, 1'b0, 0, 3, 0);
    idle(3, 3);
    pushExpect(K_RD0, 64'hDEAD, "r3_written");
    applyStimulus(1'b1, 1'b1, 3, 64'h1234, 1'b0, 0, '0, 1'b1, 3, 3, 3);
    idle(3, 3);
    pushExpect(K_RD0, 64'h0, "r3_after_reset_p0");
    pushExpect(K_RD1, 64'h0, "r3_after_reset_p1");
    pushExpect(K_BUSY, 64'h0, "busy_after_reset");
    pushExpect(K_CONF, 64'h0, "conflict_after_reset");

    // Dual write to distinct registers
    applyStimulus(1'b0, 1'b1, 5, 64'h11, 1'b1, 6, 64'h22, 1'b0, 0, 0, 0);
    idle(5, 6);
    pushExpect(K_RD0, 64'h11, "dual_r5");
    pushExpect(K_RD1, 64'h22, "dual_r6");
    pushExpect(K_CONF, 64'h0, "dual_no_conflict");

    // Same-address collision: port1 wins, one-cycle pulse
    applyStimulus(1'b0, 1'b1, 7, 64'hAA, 1'b1, 7, 64'hBB, 1'b0, 0, 7, 0);
`ifdef REGFILE_BYPASS_EN
    pushExpect(K_RD0, 64'hBB, "conflict_bypass_r7");
`else
    pushExpect(K_RD0, 64'h0, "conflict_old_r7");
`endif
    idle(7, 0);
    pushExpect(K_RD0, 64'hBB, "conflict_r7_winner");
    pushExpect(K_CONF, 64'h1, "conflict_pulse");
    idle(7, 0);
    pushExpect(K_CONF, 64'h0, "conflict_pulse_end");

    // Zero register ignores writes and reservations
    applyStimulus(1'b0, 1'b1, 31, 64'hFFFF, 1'b0, 0, '0, 1'b1, 31, 31, 0);
    pushExpect(K_RD0, 64'h0, "xzr_same_cycle");
    idle(31, 31);
    pushExpect(K_RD0, 64'h0, "xzr_read_p0");
    pushExpect(K_RD1, 64'h0, "xzr_read_p1");
    pushExpect(K_BUSY, 64'h0, "xzr_never_busy");
    pushExpect(K_RB0, 64'h0, "xzr_rd_busy");

    // Scoreboard set / clear / set-wins
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 9, 9, 0);
    idle(9, 9);
    pushExpect(K_BUSY, 64'h200, "rsv_r9_busy");
    pushExpect(K_RB0, 64'h1, "rsv_r9_rd_busy0");
    pushExpect(K_RB1, 64'h1, "rsv_r9_rd_busy1");
    applyStimulus(1'b0, 1'b1, 9, 64'h5, 1'b0, 0, '0, 1'b0, 0, 9, 0);
`ifdef REGFILE_BYPASS_EN
    pushExpect(K_RD0, 64'h5, "wr_r9_bypass_data");
    pushExpect(K_RB0, 64'h0, "wr_r9_bypass_busy");
`else
    pushExpect(K_RD0, 64'h0, "wr_r9_old_data");
    pushExpect(K_RB0, 64'h1, "wr_r9_still_busy");
`endif
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 9, 64'h6, 1'b1, 9, 9, 0);
    pushExpect(K_BUSY, 64'h0, "wr_r9_cleared");
`ifdef REGFILE_BYPASS_EN
    pushExpect(K_RD0, 64'h6, "rsv_wr_r9_bypass");
`else
    pushExpect(K_RD0, 64'h5, "rsv_wr_r9_old");
`endif
    idle(9, 0);
    pushExpect(K_BUSY, 64'h200, "set_wins_over_clear");
    pushExpect(K_RD0, 64'h6, "rsv_wr_r9_data");
    pushExpect(K_RB0, 64'h1, "set_wins_rd_busy");
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, 1'b1, 9, 9, 0);
    applyStimulus(1'b0, 1'b1, 9, 64'h7, 1'b0, 0, '0, 1'b0, 0, 9, 0);
    pushExpect(K_BUSY, 64'h200, "rsv_again_stays_busy");
    idle(9, 0);
    pushExpect(K_BUSY, 64'h0, "single_write_clears");
    pushExpect(K_RD0, 64'h7, "r9_final");

    // Same-cycle read of a register being written
    applyStimulus(1'b0, 1'b1, 4, 64'h33, 1'b0, 0, '0, 1'b0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1, 4, 64'h77, 1'b0, 0, 4, 4);
`ifdef REGFILE_BYPASS_EN
    pushExpect(K_RD0, 64'h77, "bypass_r4_p0");
    pushExpect(K_RD1, 64'h77, "bypass_r4_p1");
`else
    pushExpect(K_RD0, 64'h33, "nobypass_r4_p0");
    pushExpect(K_RD1, 64'h33, "nobypass_r4_p1");
`endif
    idle(4, 0);
    pushExpect(K_RD0, 64'h77, "r4_next_cycle");

    // Reset mid-operation discards busy bits and a pending conflict pulse
    applyStimulus(1'b0, 1'b1, 12, 64'h1, 1'b1, 12, 64'h2, 1'b1, 10, 12, 0);
    applyStimulus(1'b1, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, 12, 0);
    pushExpect(K_BUSY, 64'h400, "pre_reset_busy");
    pushExpect(K_CONF, 64'h1, "pre_reset_conflict");
    pushExpect(K_RD0, 64'h2, "pre_reset_r12");
    idle(12, 5);
    pushExpect(K_BUSY, 64'h0, "mid_reset_busy");
    pushExpect(K_CONF, 64'h0, "mid_reset_conflict");
    pushExpect(K_RD0, 64'h0, "mid_reset_r12");
    pushExpect(K_RD1, 64'h0, "mid_reset_r5");

    for (int i = 0; i < 10 && q_cyc.size() > 0; i++) @(posedge clk);
    if (q_cyc.size() > 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: %0d observations left unchecked, wanted 0", q_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
